tick_divider_bank: RTL and testbench

Parametrised bank of NCH independent clock-enable generators, each dividing `clk` by a run-time programmable divisor and producing both a 50%-duty toggle level and a single-cycle tick pulse. It generalises the fixed three-channel divider used by the game and LED front-end logic. It adds per-channel divisors, per-channel stop behaviour (pause or clear), a global phase-align strobe and asynchronous active-low reset. Downstream logic uses `tick` as a clock enable and `level` where a slow square wave is needed.

---
 rtl/tick_divider_bank_if.sv | 25 ++
 rtl/tick_divider_bank.sv | 90 +++++++++
 tb/tb_tick_divider_bank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tick_divider_bank_if.sv
// Control and status bundle for tick_divider_bank.
// The master side drives run/sync/divisor-write controls; the slave side
// (the divider bank) returns the per-channel level and tick outputs.
interface tick_divider_bank_if #(
  parameter int NCH = 3,
  parameter int CW  = 26
);
  logic           go;
  logic           sync;
  logic           load;
  logic [3:0]     load_ch;
  logic [CW-1:0]  load_div;
  logic [NCH-1:0] level;
  logic [NCH-1:0] tick;

  modport master (
    output go, sync, load, load_ch, load_div,
    input  level, tick
  );

  modport slave (
    input  go, sync, load, load_ch, load_div,
    output level, tick
  );
endinterface

// File: rtl/tick_divider_bank.sv
// Bank of NCH independent clock-enable generators. Each channel counts
// 0..div and, on reaching div, emits a one-cycle tick and toggles its level.
// Channels can pause or clear while go is low, and a sync strobe realigns
// every channel to phase zero without touching the divisors.
module tick_divider_bank #(
  parameter int                  NCH         = 3,
  parameter int                  CW          = 26,
  parameter logic [NCH*CW-1:0]   DIV_INIT    = {26'd5000000, 26'd5000000, 26'd28100},
  parameter logic [NCH-1:0]      CLR_ON_STOP = 3'b001
) (
  input  logic               clk,
  input  logic               reset,
  tick_divider_bank_if.slave bus
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  div_q [NCH];
  logic [CW-1:0]  div_d [NCH];
  logic [NCH-1:0] level_q, level_d;
  logic [NCH-1:0] tick_q,  tick_d;

  // Next-state for every channel: sync > stop > count, with divisor writes
  // applied on top in the same edge.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      level_d[i] = level_q[i];
      tick_d[i]  = 1'b0;

      if (bus.sync) begin
        cnt_d[i]   = '0;
        level_d[i] = 1'b0;
      end else if (!bus.go) begin
        if (CLR_ON_STOP[i]) begin
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      end else if (cnt_q[i] == div_q[i]) begin
        cnt_d[i]   = '0;
        level_d[i] = ~level_q[i];
        tick_d[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end

      // The terminal compare above used the old divisor; the new one takes
      // over from the next cycle. A counter that would land beyond the new
      // divisor restarts at zero so it can never run up to the 2^CW wrap.
      if (bus.load && (bus.load_ch == 4'(i))) begin
        div_d[i] = bus.load_div;
        if (cnt_d[i] > bus.load_div) begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Channel state registers; divisors return to their build-time values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        // NOTE: the divisor array is a handful of flops, not a RAM, so it is
        // safe and required to reset it to known per-channel values.
        cnt_q[i] <= '0;
        div_q[i] <= DIV_INIT[i*CW +: CW];
      end
      level_q <= '0;
      tick_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge state, independent of statement order.
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.level = level_q;
  assign bus.tick  = tick_q;

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank with NCH=3, CW=4.
// Reset divisors: ch0=3, ch1=2, ch2=1; ch0 clears on stop, ch1/ch2 pause.
module tb_tick_divider_bank;

  localparam int NCH = 3;
  localparam int CW  = 4;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  tick_divider_bank_if #(.NCH(NCH), .CW(CW)) bus ();

  tick_divider_bank #(
    .NCH         (NCH),
    .CW          (CW),
    .DIV_INIT    (12'h123),
    .CLR_ON_STOP (3'b001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "time limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge; outputs are then sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic go, input logic sync, input logic load,
                        input logic [3:0] ch, input logic [CW-1:0] dv);
    bus.go       = go;
    bus.sync     = sync;
    bus.load     = load;
    bus.load_ch  = ch;
    bus.load_div = dv;
  endtask

  // Reset with go low, check cleared outputs, release at a falling edge.
  task automatic do_reset(input string tag);
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    step();
    step();
    check({tag, "_tick"},  32'(bus.tick),  32'h0);
    check({tag, "_level"}, 32'(bus.level), 32'h0);
    reset = 1'b1;
  endtask

  // From an all-zero phase, run n edges with go=1 and check each cycle:
  // tick after edge k when k is a multiple of div+1; level is the parity
  // of completed periods.
  task automatic run_check(input string tag, input int n, input int d0, input int d1, input int d2);
    int d [3];
    logic [2:0] exp_t, exp_l;
    d[0] = d0; d[1] = d1; d[2] = d2;
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= n; k++) begin
      step();
      exp_t = '0;
      exp_l = '0;
      for (int i = 0; i < 3; i++) begin
        exp_t[i] = ((k % (d[i] + 1)) == 0);
        exp_l[i] = (((k / (d[i] + 1)) % 2) == 1);
      end
      check($sformatf("%s_tick_e%0d", tag, k),  32'(bus.tick),  32'(exp_t));
      check($sformatf("%s_level_e%0d", tag, k), 32'(bus.level), 32'(exp_l));
    end
  endtask

  initial begin
    logic [2:0] res_t [4];
    logic [2:0] res_l [4];
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);

    // Free run from reset with the build-time divisors.
    do_reset("rst1");
    run_check("run", 12, 3, 2, 1);

    // Pause vs clear: ch1 div=5 reaches cnt=2, then go low 10 cycles.
    do_reset("rst2");
    set_in(1'b0, 1'b0, 1'b1, 4'd1, 4'd5);
    step();
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    step();
    check("pre_stop_tick", 32'(bus.tick), 32'h4);
    bus.go = 1'b0;
    step();
    check("stop_first_tick", 32'(bus.tick), 32'h0);
    repeat (9) step();
    check("stop_tick",  32'(bus.tick),  32'h0);
    check("stop_level", 32'(bus.level), 32'h4);
    bus.go = 1'b1;
    res_t = '{3'b000, 3'b100, 3'b000, 3'b111};
    res_l = '{3'b100, 3'b000, 3'b000, 3'b111};
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("resume_tick_e%0d", k + 1),  32'(bus.tick),  32'(res_t[k]));
      check($sformatf("resume_level_e%0d", k + 1), 32'(bus.level), 32'(res_l[k]));
    end

    // Shrinking ch2 divisor from 12 to 4 while cnt=9 must restart the count.
    do_reset("rst3");
    set_in(1'b0, 1'b0, 1'b1, 4'd2, 4'd12);
    step();
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    repeat (9) step();
    set_in(1'b1, 1'b0, 1'b1, 4'd2, 4'd4);
    step();
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("shrink_tick2_e%0d", k), 32'(bus.tick[2]), 32'((k % 5) == 0));
    end

    // Out-of-range channel write, ch1 div=4, then sync realigns everything.
    set_in(1'b1, 1'b0, 1'b1, 4'd7, 4'd0);
    step();
    set_in(1'b1, 1'b0, 1'b1, 4'd1, 4'd4);
    step();
    set_in(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    step();
    check("sync_tick",  32'(bus.tick),  32'h0);
    check("sync_level", 32'(bus.level), 32'h0);
    run_check("post_sync", 10, 3, 4, 4);

    // Divisor 0 on ch0, written together with sync.
    set_in(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    step();
    check("sync_load_tick",  32'(bus.tick),  32'h0);
    check("sync_load_level", 32'(bus.level), 32'h0);
    run_check("div0", 4, 0, 4, 4);

    // Asynchronous reset mid-cycle clears outputs at once.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_tick",  32'(bus.tick),  32'h0);
    check("async_rst_level", 32'(bus.level), 32'h0);
    @(negedge clk);
    step();
    reset = 1'b1;
    run_check("after_rst", 6, 3, 2, 1);

    // Sync and load on the same edge while stopped.
    do_reset("rst4");
    set_in(1'b0, 1'b1, 1'b1, 4'd1, 4'd7);
    step();
    check("stop_sync_load_tick",  32'(bus.tick),  32'h0);
    check("stop_sync_load_level", 32'(bus.level), 32'h0);
    run_check("div7", 8, 3, 7, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
